// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
//
// Purpose: shared pipeline definitions for the instruction-fetch stage.
//   - WORD_W           : datapath word width (instructions, addresses)
//   - FETCH_PC_INCR    : default byte distance between sequential fetches
//   - FETCH_RESET_PC   : default program counter after reset
//   - fetch_state_e    : fetch FSM states, 2-bit encoding
//   - alignPc()        : clears the byte-offset bits of a target address
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int unsigned WORD_W = 32;

    localparam int unsigned       FETCH_PC_INCR  = 4;
    localparam logic [WORD_W-1:0] FETCH_RESET_PC = 32'h0000_0000;

    // REQ     : request outstanding (or about to be issued) at pc
    // STALLED : fetched word parked in the holding buffer, decode busy
    // FLUSH   : a redirect arrived while the old request was still in flight
    typedef enum logic [1:0] {
        FETCH_REQ     = 2'd0,
        FETCH_STALLED = 2'd1,
        FETCH_FLUSH   = 2'd2
    } fetch_state_e;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [WORD_W-1:0] alignPc(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Purpose: instruction-fetch stage. Owns the program counter, fetches from
// instruction memory over a req/ack handshake, and registers the fetched
// instruction plus its PC+PC_INCR into the IF/ID pipeline register. Copes
// with variable memory latency, decode stall and branch/jump redirects,
// including a redirect that lands while a fetch is still outstanding.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   imem_req         out  fetch request (held until imem_ack)
//   imem_addr        out  [31:0] fetch address, always the pc register
//   imem_ack         in   response valid, may arrive in the request cycle
//   imem_rdata       in   [31:0] instruction word, valid with imem_ack
//   stall            in   decode cannot accept, outputs must hold
//   redirect_valid   in   branch/jump taken this cycle
//   redirect_pc      in   [31:0] redirect target (low two bits ignored)
//   out_valid        out  out_instruction/out_pc_plus4 carry a new fetch
//   out_instruction  out  [31:0] registered instruction
//   out_pc_plus4     out  [31:0] registered fetch address + PC_INCR
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned       PC_INCR  = FETCH_PC_INCR
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_instruction,
    output logic [WORD_W-1:0] out_pc_plus4
);

    // Plain 2-bit state constants keep the register a simple vector.
    localparam logic [1:0] ST_REQ     = FETCH_REQ;
    localparam logic [1:0] ST_STALLED = FETCH_STALLED;
    localparam logic [1:0] ST_FLUSH   = FETCH_FLUSH;

    localparam logic [WORD_W-1:0] INCR = WORD_W'(PC_INCR);

    logic [1:0]        state_q,     state_d;
    logic [WORD_W-1:0] pc_q,        pc_d;
    logic [WORD_W-1:0] target_q,    target_d;
    logic [WORD_W-1:0] buf_instr_q, buf_instr_d;
    logic [WORD_W-1:0] buf_pc4_q,   buf_pc4_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_instr_q, out_instr_d;
    logic [WORD_W-1:0] out_pc4_q,   out_pc4_d;

    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] redirect_aligned;
    logic              ack_fire;

    // The request is a pure function of state so the address stays stable
    // for the whole handshake; reset kills it immediately so memory can
    // drop any request that was in flight.
    assign imem_req  = !reset && (state_q == ST_REQ || state_q == ST_FLUSH);
    assign imem_addr = pc_q;

    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_pc_plus4    = out_pc4_q;

    // An ack only counts while a request is actually being presented.
    assign ack_fire         = imem_ack && imem_req;
    // Sequential increment wraps naturally in 32-bit arithmetic.
    assign pc_next          = pc_q + INCR;
    assign redirect_aligned = alignPc(redirect_pc);

    // Next-state logic for the fetch FSM, pc, redirect target, holding
    // buffer and IF/ID register. Redirect always outranks stall because the
    // word being held is on the wrong path once a branch resolves.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc4_d   = out_pc4_q;

        case (state_q)
            ST_REQ: begin
                if (ack_fire) begin
                    if (redirect_valid) begin
                        // Returned word is on the wrong path; fetch the target next.
                        pc_d        = redirect_aligned;
                        out_valid_d = 1'b0;
                    end else if (stall) begin
                        // Decode still holds the previous word, so park this one.
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_next;
                        pc_d        = pc_next;
                        state_d     = ST_STALLED;
                    end else begin
                        out_instr_d = imem_rdata;
                        out_pc4_d   = pc_next;
                        out_valid_d = 1'b1;
                        pc_d        = pc_next;
                    end
                end else begin
                    if (redirect_valid) begin
                        // The address must stay put until the old request is
                        // acked, so the target waits in its own register.
                        target_d    = redirect_aligned;
                        out_valid_d = 1'b0;
                        state_d     = ST_FLUSH;
                    end else if (!stall) begin
                        out_valid_d = 1'b0;
                    end
                end
            end

            ST_STALLED: begin
                if (redirect_valid) begin
                    buf_instr_d = '0;
                    buf_pc4_d   = '0;
                    pc_d        = redirect_aligned;
                    out_valid_d = 1'b0;
                    state_d     = ST_REQ;
                end else if (!stall) begin
                    out_instr_d = buf_instr_q;
                    out_pc4_d   = buf_pc4_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end

            ST_FLUSH: begin
                out_valid_d = 1'b0;
                if (redirect_valid) begin
                    target_d = redirect_aligned;
                end
                if (ack_fire) begin
                    // A redirect in the same cycle as the ack is the newest one.
                    pc_d    = redirect_valid ? redirect_aligned : target_q;
                    state_d = ST_REQ;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_REQ;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            buf_instr_q <= '0;
            buf_pc4_q   <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc4_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc4_q   <= out_pc4_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Purpose: directed self-checking bench for if_fetch_unit. Memory returns
// the request address as data. Ack is either tied to imem_req (zero-wait
// mode) or driven cycle by cycle for wait-state scenarios.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc_plus4;

    logic        autoAck;
    logic        manualAck;

    int assertCount;
    int failCount;

    if_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc_plus4    (out_pc_plus4)
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: data is the address; ack is zero-wait or hand-driven.
    assign imem_ack   = autoAck ? imem_req : manualAck;
    assign imem_rdata = imem_addr;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive all stimulus inputs in one place.
    task automatic applyStimulus(input logic rst, input logic aAck, input logic mAck,
                                 input logic stl, input logic rv, input logic [31:0] rpc);
        reset          = rst;
        autoAck        = aAck;
        manualAck      = mAck;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the IF/ID register contents in one call.
    task automatic checkOut(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        checkOutput({tag, "_instr"}, out_instruction, instr);
        checkOutput({tag, "_pc4"},   out_pc_plus4, pc4);
    endtask

    task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, "_req"},  {31'd0, imem_req}, {31'd0, req});
        checkOutput({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset cycle: no request, cleared outputs.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("rst", 1'b0, 32'h0);
        checkOut("rst", 1'b0, 32'h0, 32'h0);

        // Zero-wait stream: addresses 0,4,8 with one instruction per cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkFetch("zw0", 1'b1, 32'h0);
        tick();
        checkOut("zw1", 1'b1, 32'h0, 32'h4);
        checkFetch("zw1", 1'b1, 32'h4);
        tick();
        checkOut("zw2", 1'b1, 32'h4, 32'h8);
        checkFetch("zw2", 1'b1, 32'h8);

        // Ack at 0x8 under stall, held three cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOut("stl", 1'b1, 32'h4, 32'h8);
            checkOutput("stl_req", {31'd0, imem_req}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOut("stlrel", 1'b1, 32'h8, 32'hC);
        checkFetch("stlrel", 1'b1, 32'hC);
        tick();
        checkOut("zw3", 1'b1, 32'hC, 32'h10);
        checkFetch("zw3", 1'b1, 32'h10);

        // Wait-state memory, redirect to 0x100 one cycle into req@0x10.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOut("ws1", 1'b0, 32'hC, 32'h10);
        checkFetch("ws1", 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        tick();
        checkOut("flush", 1'b0, 32'hC, 32'h10);
        checkFetch("flush", 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOut("flushack", 1'b0, 32'hC, 32'h10);
        checkFetch("flushack", 1'b1, 32'h100);

        // Two redirects during FLUSH: the latest wins.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        checkFetch("rd200", 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        checkFetch("rd300", 1'b1, 32'h100);
        checkOutput("rd300_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkFetch("rdlast", 1'b1, 32'h300);
        checkOutput("rdlast_valid", {31'd0, out_valid}, 32'd0);

        // Redirect to unaligned 0x103 while STALLED with stall held.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkFetch("stl2", 1'b0, 32'h304);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h103);
        tick();
        checkFetch("stlrd", 1'b1, 32'h100);
        checkOut("stlrd", 1'b0, 32'hC, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOut("stlrd2", 1'b0, 32'hC, 32'h10);
        checkFetch("stlrd2", 1'b1, 32'h100);

        // Acked redirect to the top word, then wrap of pc+4.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        checkFetch("top", 1'b1, 32'hFFFF_FFFC);
        checkOutput("top_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOut("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0);
        checkFetch("wrap", 1'b1, 32'h0);

        // Park word at 0x0, release it, then wait at 0x4 under stall.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOut("park", 1'b1, 32'hFFFF_FFFC, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOut("unpark", 1'b1, 32'h0, 32'h4);
        checkFetch("unpark", 1'b1, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOut("hold", 1'b1, 32'h0, 32'h4);

        // Reset in the middle of the outstanding request.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("midrst_req0", {31'd0, imem_req}, 32'd0);
        tick();
        checkFetch("midrst", 1'b0, 32'h0);
        checkOut("midrst", 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkFetch("postrst", 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
